// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port id and the
// latched command record.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Owner of the current transaction: 0 = core load/store port, 1 = DMA/debug port.
  typedef logic port_id_t;

  // Command fields are sized for the widest supported bus; the arbiter
  // zero-extends its width_p payload into them and uses only the low bits.
  localparam int unsigned ARB_MAX_W = 64;

  typedef struct packed {
    logic                 we;
    logic [ARB_MAX_W-1:0] addr;
    logic [ARB_MAX_W-1:0] wdata;
    logic [3:0]           wmask;
  } arb_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. On a tie the port that did not own the last
// transaction wins; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Combinational winner selection, one-hot or zero.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin grant, single outstanding transaction,
// busy-stretchable memory access with a sticky timeout error.
//
// state | meaning
// IDLE  | waiting for a request; grant pulses here and payload is latched
// CMD   | one-cycle memory strobe with the latched command
// WAIT  | memory busy; address held, strobes low, timeout counter running
// RESP  | one-cycle rvalid to the owning port, pointer moves to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned width_p   = 32,
  parameter int unsigned timeout_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               p0_req_i,
  input  logic               p0_we_i,
  input  logic [width_p-1:0] p0_addr_i,
  input  logic [width_p-1:0] p0_wdata_i,
  input  logic [3:0]         p0_wmask_i,
  output logic               p0_gnt_o,
  output logic               p0_rvalid_o,
  output logic [width_p-1:0] p0_rdata_o,
  input  logic               p1_req_i,
  input  logic               p1_we_i,
  input  logic [width_p-1:0] p1_addr_i,
  input  logic [width_p-1:0] p1_wdata_i,
  input  logic [3:0]         p1_wmask_i,
  output logic               p1_gnt_o,
  output logic               p1_rvalid_o,
  output logic [width_p-1:0] p1_rdata_o,
  output logic [width_p-1:0] mem_addr_o,
  output logic               mem_re_o,
  output logic               mem_we_o,
  output logic [width_p-1:0] mem_wdata_o,
  output logic [3:0]         mem_wmask_o,
  input  logic [width_p-1:0] mem_rdata_i,
  input  logic               mem_busy_i,
  output logic               err_o
);

  localparam int unsigned cnt_w_lp = $clog2(timeout_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_p - 1);

  arb_state_t            state_q, state_d;
  arb_cmd_t              cmd_q, cmd_d;
  port_id_t              owner_q, owner_d;
  logic                  last_q, last_d;
  logic [width_p-1:0]    rdata_q, rdata_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [1:0]            arb_gnt;
  logic                  unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_q;
  assign err_o = err_q;

  rr_arb2 u_rr_arb2 (
    .req  ({p1_req_i, p0_req_i}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    owner_d     = owner_q;
    last_d      = last_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    p0_gnt_o    = 1'b0;
    p1_gnt_o    = 1'b0;
    p0_rvalid_o = 1'b0;
    p1_rvalid_o = 1'b0;
    p0_rdata_o  = '0;
    p1_rdata_o  = '0;
    mem_addr_o  = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    unique case (state_q)
      IDLE: begin
        // Gating with reset keeps grant low while reset is held.
        if (reset_n_i && (arb_gnt != 2'b00)) begin
          p0_gnt_o    = arb_gnt[0];
          p1_gnt_o    = arb_gnt[1];
          owner_d     = arb_gnt[1];
          cmd_d.we    = arb_gnt[1] ? p1_we_i : p0_we_i;
          cmd_d.addr  = ARB_MAX_W'(arb_gnt[1] ? p1_addr_i : p0_addr_i);
          cmd_d.wdata = ARB_MAX_W'(arb_gnt[1] ? p1_wdata_i : p0_wdata_i);
          cmd_d.wmask = arb_gnt[1] ? p1_wmask_i : p0_wmask_i;
          state_d     = CMD;
        end
      end
      CMD: begin
        mem_re_o    = ~cmd_q.we;
        mem_we_o    = cmd_q.we;
        mem_addr_o  = cmd_q.addr[width_p-1:0];
        mem_wdata_o = cmd_q.wdata[width_p-1:0];
        mem_wmask_o = cmd_q.wmask;
        if (!mem_busy_i) begin
          rdata_d = cmd_q.we ? '0 : mem_rdata_i;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem_addr_o = cmd_q.addr[width_p-1:0];
        // Memory finishing on the last allowed cycle beats the timeout.
        if (!mem_busy_i) begin
          rdata_d = cmd_q.we ? '0 : mem_rdata_i;
          state_d = RESP;
        end else if (cnt_q == cnt_last_lp) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        p0_rvalid_o = (owner_q == 1'b0);
        p1_rvalid_o = (owner_q == 1'b1);
        p0_rdata_o  = (owner_q == 1'b0) ? rdata_q : '0;
        p1_rdata_o  = (owner_q == 1'b1) ? rdata_q : '0;
        last_d      = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command latch, pointer, counter and sticky error registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expectations at grant time,
// a negedge monitor checks strobes, grants, responses and the error flag.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int TO = 4;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          lat;
    int          gcyc;
    bit          tmo;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_v = 2'b00;
  logic [1:0]  we_v  = 2'b00;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  mask_v  [2];
  wire  [1:0]  gnt_w;
  wire  [1:0]  rvalid_w;
  wire  [31:0] rdata_w [2];
  wire  [31:0] mem_addr_w, mem_wdata_w;
  wire         mem_re_w, mem_we_w, err_w;
  wire  [3:0]  mem_wmask_w;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  logic [31:0] tb_mem  [16];
  logic [31:0] ref_mem [16];
  logic        init_done = 1'b0;
  int          pend_b [2];
  int          busy_left;

  exp_t        sb [$];
  int          gnt_log [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          busy_model = 0;
  bit          ref_last = 1;
  bit          model_err = 0;
  bit          cmd_due = 0;
  logic        cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_mask;

  mem_arbiter #(.width_p(W), .timeout_p(TO)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (rst_n),
    .p0_req_i    (req_v[0]),
    .p0_we_i     (we_v[0]),
    .p0_addr_i   (addr_v[0]),
    .p0_wdata_i  (wdata_v[0]),
    .p0_wmask_i  (mask_v[0]),
    .p0_gnt_o    (gnt_w[0]),
    .p0_rvalid_o (rvalid_w[0]),
    .p0_rdata_o  (rdata_w[0]),
    .p1_req_i    (req_v[1]),
    .p1_we_i     (we_v[1]),
    .p1_addr_i   (addr_v[1]),
    .p1_wdata_i  (wdata_v[1]),
    .p1_wmask_i  (mask_v[1]),
    .p1_gnt_o    (gnt_w[1]),
    .p1_rvalid_o (rvalid_w[1]),
    .p1_rdata_o  (rdata_w[1]),
    .mem_addr_o  (mem_addr_w),
    .mem_re_o    (mem_re_w),
    .mem_we_o    (mem_we_w),
    .mem_wdata_o (mem_wdata_w),
    .mem_wmask_o (mem_wmask_w),
    .mem_rdata_i (mem_rdata),
    .mem_busy_i  (mem_busy),
    .err_o       (err_w)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'hC3C3_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: word array, combinational read, busy held for a chosen
  // number of cycles starting with the command cycle.
  assign mem_rdata = tb_mem[mem_addr_w[5:2]];
  assign mem_busy  = (busy_left != 0);

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)          busy_left <= 0;
    else if (gnt_w[0])   busy_left <= pend_b[0];
    else if (gnt_w[1])   busy_left <= pend_b[1];
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end

  always @(posedge clk_i) begin
    if (!init_done) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (mem_we_w) begin
      for (int k = 0; k < 4; k++)
        if (mem_wmask_w[k]) tb_mem[mem_addr_w[5:2]][8*k +: 8] <= mem_wdata_w[8*k +: 8];
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    logic [1:0] exp_g;
    int w, wc;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        chk(gnt_w == 2'b00 && rvalid_w == 2'b00 && !mem_re_w && !mem_we_w, "reset_ctl",
            32'({gnt_w, rvalid_w, mem_re_w, mem_we_w}), 32'h0);
        chk(mem_addr_w == 0 && mem_wdata_w == 0 && mem_wmask_w == 0, "reset_mem",
            mem_addr_w | mem_wdata_w | 32'(mem_wmask_w), 32'h0);
        chk(rdata_w[0] == 0 && rdata_w[1] == 0, "reset_rdata", rdata_w[0] | rdata_w[1], 32'h0);
        chk(err_w == 1'b0, "reset_err", 32'(err_w), 32'h0);
        sb.delete();
        busy_model = 0; ref_last = 1; model_err = 0; cmd_due = 0;
      end else begin
        cyc++;
        if (cmd_due) begin
          chk(mem_re_w == !cmd_we && mem_we_w == cmd_we, "cmd_strobe",
              32'({mem_re_w, mem_we_w}), 32'({!cmd_we, cmd_we}));
          chk(mem_addr_w == cmd_addr, "cmd_addr", mem_addr_w, cmd_addr);
          if (cmd_we) begin
            chk(mem_wdata_w == cmd_wdata, "cmd_wdata", mem_wdata_w, cmd_wdata);
            chk(mem_wmask_w == cmd_mask, "cmd_wmask", 32'(mem_wmask_w), 32'(cmd_mask));
          end
          cmd_due = 0;
        end else begin
          chk(!mem_re_w && !mem_we_w, "stray_strobe", 32'({mem_re_w, mem_we_w}), 32'h0);
        end
        exp_g = 2'b00;
        if (!busy_model && req_v != 2'b00)
          exp_g = (req_v == 2'b11) ? (ref_last ? 2'b01 : 2'b10) : req_v;
        chk(gnt_w == exp_g, "grant", 32'(gnt_w), 32'(exp_g));
        if (gnt_w == 2'b01 || gnt_w == 2'b10) begin
          w = gnt_w[1] ? 1 : 0;
          gnt_log.push_back(w);
          e.port = w;
          e.gcyc = cyc;
          e.tmo  = (pend_b[w] > TO);
          wc     = e.tmo ? TO : pend_b[w];
          e.lat  = 2 + wc;
          if (we_v[w]) begin
            ref_mem[addr_v[w][5:2]] = merge(ref_mem[addr_v[w][5:2]], wdata_v[w], mask_v[w]);
            e.data = 32'h0;
          end else begin
            e.data = e.tmo ? 32'h0 : ref_mem[addr_v[w][5:2]];
          end
          sb.push_back(e);
          cmd_due = 1; cmd_we = we_v[w]; cmd_addr = addr_v[w];
          cmd_wdata = wdata_v[w]; cmd_mask = mask_v[w];
          busy_model = 1; ref_last = gnt_w[1];
        end
        if (rvalid_w != 2'b00) begin
          chk(rvalid_w != 2'b11, "double_rvalid", 32'(rvalid_w), 32'h1);
          chk(sb.size() != 0, "unexpected_rvalid", 32'(rvalid_w), 32'h0);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(rvalid_w == (e.port == 1 ? 2'b10 : 2'b01), "resp_port", 32'(rvalid_w),
                32'(e.port == 1 ? 2'b10 : 2'b01));
            chk(rdata_w[e.port] == e.data, "resp_data", rdata_w[e.port], e.data);
            chk(cyc - e.gcyc == e.lat, "resp_latency", 32'(cyc - e.gcyc), 32'(e.lat));
            if (e.tmo) model_err = 1;
          end
          busy_model = 0;
        end
        for (int p = 0; p < 2; p++)
          if (!rvalid_w[p]) chk(rdata_w[p] == 0, "rdata_idle_zero", rdata_w[p], 32'h0);
        chk(err_w == model_err, "err_flag", 32'(err_w), 32'(model_err));
      end
    end
  end

  task automatic do_txn(input int p, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask, input int b);
    bit got;
    got = 0;
    pend_b[p]  = b;
    we_v[p]    = we;
    addr_v[p]  = addr;
    wdata_v[p] = wdata;
    mask_v[p]  = mask;
    req_v[p]   = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk_i);
      if (gnt_w[p]) got = 1;
    end
    chk(got, "grant_wait", 32'(got), 32'h1);
    @(posedge clk_i); #1;
    req_v[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (!busy_model && sb.size() == 0) done = 1;
    end
    chk(done, "idle_wait", 32'(sb.size()), 32'h0);
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #0;
      do_txn(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 6));
    end
  endtask

  task automatic stream_port(input int p, input int n);
    for (int i = 0; i < n; i++)
      do_txn(p, 1'(i % 2), 32'(8 + 4 * p) << 2, $urandom, 4'hF, $urandom_range(0, 2));
  endtask

  initial begin
    bit alt_ok;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      addr_v[p] = '0; wdata_v[p] = '0; mask_v[p] = '0; pend_b[p] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n = 1'b1;

    // Single read with one busy cycle.
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1);
    wait_idle();
    // Full write without busy, then read it back.
    do_txn(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 0);
    wait_idle();
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    wait_idle();
    // Partial write stretched by three busy cycles, then read back.
    do_txn(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h3, 3);
    wait_idle();
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    wait_idle();

    // Continuous contention from reset: grants must alternate starting with p0.
    do_reset();
    gnt_log.delete();
    fork
      stream_port(0, 4);
      stream_port(1, 4);
    join
    wait_idle();
    alt_ok = (gnt_log.size() == 8);
    for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] != i % 2) alt_ok = 0;
    chk(alt_ok, "contention_alternate", 32'(gnt_log.size()), 32'd8);

    // Timeout: busy outlasts the limit; err stays set afterwards.
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 7);
    wait_idle();
    do_txn(0, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, 0);
    wait_idle();
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 2);
    wait_idle();

    // Reset during WAIT abandons the read; next tie goes to p0.
    do_txn(0, 1'b0, 32'hC, 32'h0, 4'h0, 7);
    @(posedge clk_i); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    gnt_log.delete();
    fork
      do_txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0);
      do_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    join
    wait_idle();
    chk(gnt_log.size() == 2 && gnt_log[0] == 0, "tie_after_reset",
        32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'h0);

    // Randomised traffic from both ports.
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join
    wait_idle();
    chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
